bsg_manycore_pod_link_retimer: RTL and testbench

Parametrised pipelined retiming block for the long horizontal inter-pod boundary between adjacent pods in a pod row. It carries `num_channels_p` independent valid/ready-and channels and a bundle of barrier wires across `num_stages_p` buffered stages while sustaining full throughput. It adds an isolation mode that stops new traffic, drains in-flight words, and forces barrier wires to their edge tie-off values. This lets one pod be fenced off from its neighbour without reset.

---
 rtl/bsg_manycore_pod_link_retimer.sv | 144 ++++++++++++++
 tb/tb_bsg_manycore_pod_link_retimer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_pod_link_retimer.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_pod_link_retimer
// Purpose  : Pipelined retimer for the inter-pod boundary. It carries several
//            valid/ready-and channels through chains of two-entry FIFOs, and
//            barrier wires through plain flops. An isolation mode blocks new
//            traffic, drains in-flight words and ties barriers off.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_manycore_pod_link_retimer #(
    parameter int num_channels_p = 4,
    parameter int width_p = 32,
    parameter int num_stages_p = 2,
    parameter int num_barrier_p = 4,
    parameter logic [num_barrier_p-1:0] barrier_tieoff_p = '0,
    localparam int count_width_lp = $clog2(2*num_stages_p+1)
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic                                         isolate_i,
    output logic                                         isolated_o,
    input  logic [num_channels_p-1:0]                    v_i,
    input  logic [num_channels_p-1:0][width_p-1:0]       data_i,
    output logic [num_channels_p-1:0]                    ready_and_o,
    output logic [num_channels_p-1:0]                    v_o,
    output logic [num_channels_p-1:0][width_p-1:0]       data_o,
    input  logic [num_channels_p-1:0]                    ready_and_i,
    input  logic [num_barrier_p-1:0]                     barrier_i,
    output logic [num_barrier_p-1:0]                     barrier_o,
    output logic [num_channels_p-1:0][count_width_lp-1:0] count_o
);

    localparam logic [1:0] c_fifo_empty = 2'd0;
    localparam logic [1:0] c_fifo_one   = 2'd1;
    localparam logic [1:0] c_fifo_full  = 2'd2;

    logic [num_channels_p-1:0] w_zero;
    logic                      r_isolated;
    logic [num_barrier_p-1:0]  r_bar [num_stages_p];

    for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
        logic [num_stages_p-1:0]   w_enq;
        logic [num_stages_p-1:0]   w_deq;
        logic [width_p-1:0]        w_din [num_stages_p];
        logic [1:0]                r_cnt [num_stages_p];
        logic [width_p-1:0]        r_d0  [num_stages_p];
        logic [width_p-1:0]        r_d1  [num_stages_p];
        logic [count_width_lp-1:0] r_count;
        logic [count_width_lp-1:0] w_count_next;
        logic                      w_in_hs;
        logic                      w_out_hs;

        // Ready and valid come only from stage occupancy registers; reset
        // suppresses both so no handshake can happen in a reset cycle.
        assign ready_and_o[c] = (r_cnt[0] != c_fifo_full) & ~isolate_i & ~reset_i;
        assign v_o[c]         = (r_cnt[num_stages_p-1] != c_fifo_empty) & ~reset_i;
        assign data_o[c]      = r_d0[num_stages_p-1];
        assign w_in_hs        = v_i[c] & ready_and_o[c];
        assign w_out_hs       = v_o[c] & ready_and_i[c];

        // Stage-to-stage transfers: a word moves when the upstream stage holds
        // one and the downstream stage has room.
        always_comb begin
            w_enq    = '0;
            w_deq    = '0;
            w_din[0] = data_i[c];
            w_enq[0] = w_in_hs;
            for (int s = 1; s < num_stages_p; s++) begin
                w_din[s]   = r_d0[s-1];
                w_enq[s]   = (r_cnt[s-1] != c_fifo_empty) & (r_cnt[s] != c_fifo_full);
                w_deq[s-1] = w_enq[s];
            end
            w_deq[num_stages_p-1] = w_out_hs;
        end

        // Two-entry FIFO per stage; r_d0 is always the head entry.
        always_ff @(posedge clk_i) begin
            for (int s = 0; s < num_stages_p; s++) begin
                if (reset_i) begin
                    r_cnt[s] <= c_fifo_empty;
                end else begin
                    case ({w_enq[s], w_deq[s]})
                        2'b10: begin
                            if (r_cnt[s] == c_fifo_empty) r_d0[s] <= w_din[s];
                            else                          r_d1[s] <= w_din[s];
                            r_cnt[s] <= r_cnt[s] + 2'd1;
                        end
                        2'b01: begin
                            r_d0[s]  <= r_d1[s];
                            r_cnt[s] <= r_cnt[s] - 2'd1;
                        end
                        2'b11: begin
                            if (r_cnt[s] == c_fifo_one) begin
                                r_d0[s] <= w_din[s];
                            end else begin
                                r_d0[s] <= r_d1[s];
                                r_d1[s] <= w_din[s];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        // Occupancy moves by one per lone handshake and holds otherwise.
        always_comb begin
            w_count_next = r_count;
            if (w_in_hs & ~w_out_hs)      w_count_next = r_count + 1'b1;
            else if (~w_in_hs & w_out_hs) w_count_next = r_count - 1'b1;
        end

        // Occupancy register.
        always_ff @(posedge clk_i) begin
            if (reset_i) r_count <= '0;
            else         r_count <= w_count_next;
        end

        assign w_zero[c]  = (w_count_next == '0);
        assign count_o[c] = r_count;
    end

    // Isolation is reported once every channel is empty after this cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) r_isolated <= 1'b0;
        else         r_isolated <= isolate_i & (&w_zero);
    end

    assign isolated_o = r_isolated;

    // Barrier shift chain; no backpressure, tie-off enters while isolated.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < num_stages_p; s++) r_bar[s] <= barrier_tieoff_p;
        end else begin
            r_bar[0] <= isolate_i ? barrier_tieoff_p : barrier_i;
            for (int s = 1; s < num_stages_p; s++) r_bar[s] <= r_bar[s-1];
        end
    end

    assign barrier_o = r_bar[num_stages_p-1];

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_pod_link_retimer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_manycore_pod_link_retimer
// Purpose  : Self-checking bench for the pod link retimer: reset, vector
//            table, streaming, isolation, barrier, mid-transfer reset and a
//            random phase checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_manycore_pod_link_retimer;

    localparam int          C  = 4;
    localparam int          W  = 32;
    localparam int          S  = 2;
    localparam int          B  = 4;
    localparam logic [B-1:0] T = 4'hA;
    localparam int          CW = $clog2(2*S+1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 isolate;
    logic                 isolated_o;
    logic [C-1:0]         v_i;
    logic [C-1:0][W-1:0]  data_i;
    logic [C-1:0]         ready_o;
    logic [C-1:0]         v_o;
    logic [C-1:0][W-1:0]  data_o;
    logic [C-1:0]         rdy_i;
    logic [B-1:0]         barrier_i;
    logic [B-1:0]         barrier_o;
    logic [C-1:0][CW-1:0] count_o;

    bsg_manycore_pod_link_retimer #(
        .num_channels_p(C), .width_p(W), .num_stages_p(S),
        .num_barrier_p(B), .barrier_tieoff_p(T)
    ) dut (
        .clk_i(clk), .reset_i(reset), .isolate_i(isolate), .isolated_o(isolated_o),
        .v_i(v_i), .data_i(data_i), .ready_and_o(ready_o),
        .v_o(v_o), .data_o(data_o), .ready_and_i(rdy_i),
        .barrier_i(barrier_i), .barrier_o(barrier_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Each channel is an ordered word list bounded by 2*S; barriers are a
    // pure S-cycle delay line.
    logic [W-1:0]  mq [C][16];
    int            mh [C];
    int            ms [C];
    int            stall [C];
    logic          exp_iso;
    logic          model_ok = 1'b0;
    logic [B-1:0]  bq [$];
    logic          all0;

    always @(negedge clk) begin
        if (model_ok) begin
            chk("barrier_o", 64'(barrier_o), 64'(bq[0]));
            chk("isolated_o", 64'(isolated_o), 64'(exp_iso));
            for (int c = 0; c < C; c++) begin
                chk("count_o", 64'(count_o[c]), 64'(ms[c]));
                if (reset) begin
                    chk("ready_in_reset", 64'(ready_o[c]), 64'd0);
                    chk("v_o_in_reset", 64'(v_o[c]), 64'd0);
                end else begin
                    if (isolate || ms[c] >= 2*S)
                        chk("ready_blocked", 64'(ready_o[c]), 64'd0);
                    else if (ms[c] == 0)
                        chk("ready_when_empty", 64'(ready_o[c]), 64'd1);
                    if (ms[c] == 0)
                        chk("v_o_when_empty", 64'(v_o[c]), 64'd0);
                    else if (v_o[c])
                        chk("data_order", 64'(data_o[c]), 64'(mq[c][mh[c]]));
                    if (ms[c] != 0 && !v_o[c]) stall[c]++;
                    else                       stall[c] = 0;
                    if (ms[c] != 0)
                        chk("v_o_progress", 64'(stall[c] > S), 64'd0);
                end
            end
        end
        if (reset) begin
            for (int c = 0; c < C; c++) begin
                ms[c] = 0; mh[c] = 0; stall[c] = 0;
            end
            exp_iso = 1'b0;
            bq.delete();
            for (int s = 0; s < S; s++) bq.push_back(T);
            model_ok = 1'b1;
        end else if (model_ok) begin
            all0 = 1'b1;
            for (int c = 0; c < C; c++) begin
                if (v_o[c] && rdy_i[c] && ms[c] > 0) begin
                    mh[c] = (mh[c] + 1) % 16;
                    ms[c]--;
                end
                if (v_i[c] && ready_o[c]) begin
                    mq[c][(mh[c] + ms[c]) % 16] = data_i[c];
                    ms[c]++;
                end
                if (ms[c] != 0) all0 = 1'b0;
            end
            exp_iso = isolate && all0;
            bq.push_back(isolate ? T : barrier_i);
            void'(bq.pop_front());
        end
    end

    // ---------------- vector table (channel 0 backpressure) ----------------
    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        er;
        logic        ev;
        logic [7:0]  ed;
        logic [2:0]  ec;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rdy,
                                input logic er, input logic ev, input logic [7:0] ed,
                                input logic [2:0] ec);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.er = er; r.ev = ev; r.ed = ed; r.ec = ec;
        return r;
    endfunction

    logic [B-1:0] pat [10];
    int zc, ic, got0, got1;
    logic iso_mode;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //            v  d  rdy er ev ed ec
        tbl[0]  = mk(1, 0, 0,  1, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0,  1, 0, 0, 1);
        tbl[2]  = mk(1, 2, 0,  1, 1, 0, 2);
        tbl[3]  = mk(1, 3, 0,  1, 1, 0, 3);
        tbl[4]  = mk(1, 4, 0,  0, 1, 0, 4);
        tbl[5]  = mk(1, 4, 1,  0, 1, 0, 4);
        tbl[6]  = mk(1, 4, 1,  0, 1, 1, 3);
        tbl[7]  = mk(1, 4, 1,  1, 1, 2, 2);
        tbl[8]  = mk(1, 5, 1,  1, 1, 3, 2);
        tbl[9]  = mk(0, 0, 1,  1, 1, 4, 2);
        tbl[10] = mk(0, 0, 1,  1, 1, 5, 1);
        tbl[11] = mk(0, 0, 1,  1, 0, 0, 0);

        reset = 1'b1; isolate = 1'b0; v_i = '1; data_i = '0; rdy_i = '1; barrier_i = 4'h5;

        // Reset held three cycles with every input valid.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ready", 64'(ready_o), 64'd0);
            chk("rst_v_o", 64'(v_o), 64'd0);
            chk("rst_count", 64'(count_o), 64'd0);
            chk("rst_barrier", 64'(barrier_o), 64'(T));
            chk("rst_isolated", 64'(isolated_o), 64'd0);
            nxt();
        end
        reset = 1'b0; v_i = '0;
        @(negedge clk);
        chk("post_rst_ready", 64'(ready_o), 64'hF);
        nxt();

        // Table: stall channel 0, overfill, then release.
        for (int i = 0; i < 12; i++) begin
            v_i = {3'b000, tbl[i].v};
            data_i[0] = {24'h0, tbl[i].d};
            rdy_i = {3'b111, tbl[i].rdy};
            @(negedge clk);
            chk("tbl_ready", 64'(ready_o[0]), 64'(tbl[i].er));
            chk("tbl_v_o", 64'(v_o[0]), 64'(tbl[i].ev));
            if (tbl[i].ev) chk("tbl_data", 64'(data_o[0]), 64'(tbl[i].ed));
            chk("tbl_count", 64'(count_o[0]), 64'(tbl[i].ec));
            nxt();
        end

        // Streaming 100 words on channel 0.
        rdy_i = '1;
        for (int k = 0; k < 104; k++) begin
            v_i = (k < 100) ? 4'b0001 : 4'b0000;
            data_i[0] = 32'(k);
            @(negedge clk);
            chk("stream_ready", 64'(ready_o[0]), 64'd1);
            chk("stream_v_o", 64'(v_o[0]), 64'(k >= 2 && k < 102));
            if (k >= 2 && k < 102) chk("stream_data", 64'(data_o[0]), 64'(k - 2));
            chk("stream_count", 64'(count_o[0]),
                64'((k == 0) ? 0 : (k == 1) ? 1 : (k <= 100) ? 2 : (k == 101) ? 1 : 0));
            nxt();
        end

        // Simultaneous handshakes on channel 2 hold the count constant.
        for (int k = 0; k < 54; k++) begin
            v_i = 4'b0100;
            data_i[2] = $urandom;
            @(negedge clk);
            if (k >= 2 && k < 52) begin
                chk("simul_count", 64'(count_o[2]), 64'd2);
                chk("simul_hs", 64'({v_i[2] & ready_o[2], v_o[2] & rdy_i[2]}), 64'd3);
            end
            nxt();
        end
        v_i = '0;
        repeat (4) nxt();

        // Isolation with three words queued on channels 0 and 1.
        rdy_i = '0;
        for (int k = 0; k < 3; k++) begin
            v_i = 4'b0011;
            data_i[0] = 32'h100 + 32'(k);
            data_i[1] = 32'h200 + 32'(k);
            nxt();
        end
        isolate = 1'b1; rdy_i = '1; v_i = '1;
        zc = -1; ic = -1; got0 = 0; got1 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) chk("iso_ready", 64'(ready_o), 64'd0);
            if (k < 2)  chk("iso_barrier_old", 64'(barrier_o), 64'h5);
            if (k == 2) chk("iso_barrier_tie", 64'(barrier_o), 64'(T));
            if (v_o[0]) got0++;
            if (v_o[1]) got1++;
            if (count_o == '0 && zc < 0) zc = k;
            if (isolated_o && ic < 0) ic = k;
            nxt();
        end
        chk("iso_delivered_ch0", 64'(got0), 64'd3);
        chk("iso_delivered_ch1", 64'(got1), 64'd3);
        chk("iso_drain_cycle", 64'(zc), 64'd3);
        chk("iso_rise_cycle", 64'(ic), 64'd3);
        isolate = 1'b0; v_i = '0;
        @(negedge clk);
        chk("deiso_ready", 64'(ready_o), 64'hF);
        chk("deiso_isolated_hold", 64'(isolated_o), 64'd1);
        nxt();
        @(negedge clk);
        chk("deiso_isolated_fall", 64'(isolated_o), 64'd0);
        nxt();

        // Walking-one barrier with channels stalled.
        rdy_i = '0; v_i = '0;
        for (int k = 0; k < 10; k++) pat[k] = 4'(1 << (k % 4));
        for (int k = 0; k < 12; k++) begin
            barrier_i = (k < 10) ? pat[k] : 4'h0;
            @(negedge clk);
            if (k >= 2) chk("barrier_delay", 64'(barrier_o), 64'(pat[k - 2]));
            nxt();
        end

        // Reset while words are in flight.
        for (int k = 0; k < 3; k++) begin
            v_i = '1;
            for (int c = 0; c < C; c++) data_i[c] = 32'hDEAD_0000 + 32'(c * 16 + k);
            nxt();
        end
        reset = 1'b1; rdy_i = '1;
        @(negedge clk);
        chk("midrst_v_o", 64'(v_o), 64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        nxt();
        reset = 1'b0; v_i = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) chk("midrst_count", 64'(count_o), 64'd0);
            chk("midrst_no_stale", 64'(v_o), 64'd0);
            nxt();
        end

        // Random traffic against the reference model.
        iso_mode = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            v_i = 4'($urandom);
            for (int c = 0; c < C; c++) begin
                data_i[c] = $urandom;
                rdy_i[c]  = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 39) == 0) iso_mode = ~iso_mode;
            isolate   = iso_mode;
            reset     = ($urandom_range(0, 299) == 0);
            barrier_i = 4'($urandom);
            nxt();
        end
        reset = 1'b0; isolate = 1'b0; v_i = '0; rdy_i = '1;
        repeat (8) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
